ll_memory_responder: RTL and testbench

Lower-level memory responder for the L2's single lower-level port. It accepts one request at a time on the enable/write/addr/data interface and returns readyToL2 after a parameterised fixed latency. It returns read data on the same cycle as ready, or commits write data on the ready cycle. The block sits below the L2 as the main-memory model for simulation and as the synthesizable backing store for FPGA builds.

---
 rtl/ll_memory_responder.sv | 149 ++++++++++++++
 tb/tb_ll_memory_responder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ll_memory_responder.sv
// Fixed-latency backing memory beneath the L2: one request at a time, registered
// single-cycle response with read data, write echo and an out-of-range flag.
module ll_memory_responder #(
    parameter int unsigned DEPTH   = 32'd4096,
    parameter int unsigned RDLAT   = 32'd4,
    parameter int unsigned WRLAT   = 32'd2,
    parameter logic [31:0] ERRDATA = 32'hDEAD_BEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addrFromL2,
    input  logic        enableFromL2,
    input  logic        writeFromL2,
    input  logic [31:0] dataFromL2,
    output logic [31:0] dataToL2,
    output logic        readyToL2,
    output logic        errToL2,
    output logic        busyToL2
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned MAXLAT = (RDLAT > WRLAT) ? RDLAT : WRLAT;
    localparam int unsigned CW     = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wr_q, wr_d;
    logic            oor_q, oor_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     data_q, data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [CW-1:0]   lat_m1;
    logic            go_resp;

    logic [31:0]     mem [DEPTH];

    // Byte offset within a word carries no information for a word-wide memory.
    logic [1:0]      unused_addr_lsbs;
    assign unused_addr_lsbs = addrFromL2[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        data_d  = '0;
        ready_d = 1'b0;
        err_d   = 1'b0;
        lat_m1  = '0;
        go_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enableFromL2) begin
                    idx_d   = addrFromL2[AW+1:2];
                    wr_d    = writeFromL2;
                    wdata_d = dataFromL2;
                    oor_d   = |addrFromL2[31:AW+2];
                    lat_m1  = writeFromL2 ? CW'(WRLAT - 1) : CW'(RDLAT - 1);
                    cnt_d   = lat_m1;
                    if (lat_m1 == '0) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!enableFromL2) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q <= CW'(1)) begin
                        go_resp = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response fields are computed from the request as it will be latched,
        // so a zero-wait request can go straight from IDLE to RESP.
        if (go_resp) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = oor_d;
            if (wr_d) begin
                data_d = wdata_d;
            end else if (oor_d) begin
                data_d = ERRDATA;
            end else begin
                data_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Commit happens on the RESP->IDLE edge; a reset already forces IDLE, so
    // a pending write is dropped.
    always_ff @(posedge clock) begin
        if (state_q == ST_RESP && wr_q && !oor_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign dataToL2  = data_q;
    assign readyToL2 = ready_q;
    assign errToL2   = err_q;
    assign busyToL2  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ll_memory_responder.sv
// Directed bench for ll_memory_responder: three instances cover default latencies,
// single-cycle latencies and a three-cycle write latency for the mid-write reset case.
module tb_ll_memory_responder;

    logic        clock = 1'b0;
    logic        rst_n  [3];
    logic [31:0] addr   [3];
    logic        en     [3];
    logic        wr     [3];
    logic [31:0] wdata  [3];
    logic [31:0] dout   [3];
    logic        ready  [3];
    logic        err    [3];
    logic        busy   [3];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    ll_memory_responder #(.DEPTH(4096), .RDLAT(4), .WRLAT(2), .ERRDATA(32'hDEAD_BEEF)) dut_default (
        .clock(clock), .reset(rst_n[0]), .addrFromL2(addr[0]), .enableFromL2(en[0]),
        .writeFromL2(wr[0]), .dataFromL2(wdata[0]), .dataToL2(dout[0]),
        .readyToL2(ready[0]), .errToL2(err[0]), .busyToL2(busy[0])
    );

    ll_memory_responder #(.DEPTH(4096), .RDLAT(1), .WRLAT(1), .ERRDATA(32'hDEAD_BEEF)) dut_fast (
        .clock(clock), .reset(rst_n[1]), .addrFromL2(addr[1]), .enableFromL2(en[1]),
        .writeFromL2(wr[1]), .dataFromL2(wdata[1]), .dataToL2(dout[1]),
        .readyToL2(ready[1]), .errToL2(err[1]), .busyToL2(busy[1])
    );

    ll_memory_responder #(.DEPTH(4096), .RDLAT(4), .WRLAT(3), .ERRDATA(32'hDEAD_BEEF)) dut_w3 (
        .clock(clock), .reset(rst_n[2]), .addrFromL2(addr[2]), .enableFromL2(en[2]),
        .writeFromL2(wr[2]), .dataFromL2(wdata[2]), .dataToL2(dout[2]),
        .readyToL2(ready[2]), .errToL2(err[2]), .busyToL2(busy[2])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Single isolated transaction: measures edges from acceptance to ready,
    // checks the response, then drops enable and confirms the return to idle.
    task automatic applyStimulus(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                                 input string tag);
        int lat;
        lat = 0;
        @(posedge clock); #1;
        en[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!ready[i] && lat < 20);
        checkOutput({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, ".data"}, dout[i], exp_data);
        checkOutput({tag, ".err"}, 32'(err[i]), 32'(exp_err));
        en[i] = 1'b0;
        @(posedge clock); #1;
        checkOutput({tag, ".idle"}, {30'd0, ready[i], busy[i]}, 32'd0);
    endtask

    initial begin
        int n;
        int c1;
        int c2;
        logic seen;
        logic        sw [4];
        logic [31:0] sd [4];
        logic [31:0] se [4];

        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; en[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
        #3;
        checkOutput("reset.data", dout[0], 32'd0);
        checkOutput("reset.ctrl", {29'd0, ready[0], err[0], busy[0]}, 32'd0);
        checkOutput("reset.fast", {29'd0, ready[1], err[1], busy[1]}, 32'd0);
        #9;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Default latencies: write then read back
        applyStimulus(0, 1'b1, 32'h0000_0040, 32'hA5A5_1234, 2, 32'hA5A5_1234, 1'b0, "wr40");
        applyStimulus(0, 1'b0, 32'h0000_0040, 32'h0, 4, 32'hA5A5_1234, 1'b0, "rd40");
        applyStimulus(0, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 1'b0, "wr44");

        // Back-to-back reads with enable held high
        @(posedge clock); #1;
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0040;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!ready[0] && n < 20);
        c1 = cycle;
        checkOutput("b2b.lat1", 32'(n), 32'd4);
        checkOutput("b2b.data1", dout[0], 32'hA5A5_1234);
        @(posedge clock); #1;
        addr[0] = 32'h0000_0044;
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!ready[0] && n < 20);
        c2 = cycle;
        checkOutput("b2b.gap", 32'(c2 - c1), 32'd5);
        checkOutput("b2b.data2", dout[0], 32'h0BAD_F00D);
        checkOutput("b2b.err2", 32'(err[0]), 32'd0);
        en[0] = 1'b0;
        @(posedge clock); #1;

        // Abort after two WAIT cycles
        @(posedge clock); #1;
        en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_0080;
        @(posedge clock); #1;
        checkOutput("abort.busy", 32'(busy[0]), 32'd1);
        @(posedge clock); #1;
        en[0] = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clock); #1; seen |= ready[0]; end
        checkOutput("abort.noready", 32'(seen), 32'd0);
        checkOutput("abort.idle", 32'(busy[0]), 32'd0);
        applyStimulus(0, 1'b1, 32'h0000_0080, 32'h5555_AAAA, 2, 32'h5555_AAAA, 1'b0, "abort.wr");
        applyStimulus(0, 1'b0, 32'h0000_0080, 32'h0, 4, 32'h5555_AAAA, 1'b0, "abort.rd");

        // Out-of-range write aliases word 0 but must not touch it
        applyStimulus(0, 1'b1, 32'h0000_0000, 32'h0000_0077, 2, 32'h0000_0077, 1'b0, "wr0");
        applyStimulus(0, 1'b1, 32'h0001_0000, 32'h1111_1111, 2, 32'h1111_1111, 1'b1, "oor.wr");
        applyStimulus(0, 1'b0, 32'h0001_0000, 32'h0, 4, 32'hDEAD_BEEF, 1'b1, "oor.rd");
        applyStimulus(0, 1'b0, 32'h0000_0000, 32'h0, 4, 32'h0000_0077, 1'b0, "rd0");

        // Reset in the second WAIT cycle of a WRLAT=3 write
        applyStimulus(2, 1'b1, 32'h0000_0020, 32'h0000_00AA, 3, 32'h0000_00AA, 1'b0, "w3.init");
        @(posedge clock); #1;
        en[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h0000_0020; wdata[2] = 32'hFFFF_0000;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checkOutput("w3.busy", 32'(busy[2]), 32'd1);
        rst_n[2] = 1'b0; en[2] = 1'b0;
        #1;
        checkOutput("w3.rst.ctrl", {29'd0, ready[2], err[2], busy[2]}, 32'd0);
        checkOutput("w3.rst.data", dout[2], 32'd0);
        seen = 1'b0;
        @(posedge clock); #1; seen |= ready[2];
        rst_n[2] = 1'b1;
        repeat (4) begin @(posedge clock); #1; seen |= ready[2]; end
        checkOutput("w3.noready", 32'(seen), 32'd0);
        applyStimulus(2, 1'b0, 32'h0000_0020, 32'h0, 4, 32'h0000_00AA, 1'b0, "w3.rd");

        // Single-cycle latencies: streamed alternating write/read to 0x8
        sw[0] = 1'b1; sd[0] = 32'h1111_0001; se[0] = 32'h1111_0001;
        sw[1] = 1'b0; sd[1] = 32'h0;         se[1] = 32'h1111_0001;
        sw[2] = 1'b1; sd[2] = 32'h2222_0002; se[2] = 32'h2222_0002;
        sw[3] = 1'b0; sd[3] = 32'h0;         se[3] = 32'h2222_0002;
        @(posedge clock); #1;
        en[1] = 1'b1; addr[1] = 32'h0000_0008; wr[1] = sw[0]; wdata[1] = sd[0];
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin @(posedge clock); #1; n++; end while (!ready[1] && n < 20);
            checkOutput($sformatf("fast%0d.period", k), 32'(n), (k == 0) ? 32'd1 : 32'd2);
            checkOutput($sformatf("fast%0d.data", k), dout[1], se[k]);
            if (k < 3) begin
                wr[1] = sw[k+1]; wdata[1] = sd[k+1];
            end
        end
        en[1] = 1'b0;
        @(posedge clock); #1;
        checkOutput("fast.idle", {30'd0, ready[1], busy[1]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
